// File: rtl/cube_scanner.sv
// Parametrised LED-cube scan driver: snapshots the cell array once per frame
// and scans layer/row with blanking, dwell and PWM brightness on Enable_n.
module cube_scanner #(
    parameter int COLS   = 8,
    parameter int ROWS   = 8,
    parameter int LAYERS = 8,
    parameter int DWELL  = 16,
    parameter int BLANK  = 2,
    parameter int BW     = $clog2(DWELL + 1)
) (
    input  logic                          Clk,
    input  logic                          Rst_n,
    input  logic [LAYERS*ROWS*COLS-1:0]   Cells,
    input  logic                          Run,
    input  logic [BW-1:0]                 Brightness,
    output logic [$clog2(LAYERS)-1:0]     Layer,
    output logic [$clog2(ROWS)-1:0]       Row,
    output logic [COLS-1:0]               Data,
    output logic                          Enable_n,
    output logic                          Frame_load,
    output logic                          Frame_done
);

    localparam int LW   = $clog2(LAYERS);
    localparam int RW   = $clog2(ROWS);
    localparam int NR   = LAYERS * ROWS;
    localparam int IW   = $clog2(NR);
    localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] BL_LAST = CW'(BLANK - 1);
    localparam logic [CW-1:0] DW_LAST = CW'(DWELL - 1);
    localparam logic [LW-1:0] L_LAST  = LW'(LAYERS - 1);
    localparam logic [RW-1:0] R_LAST  = RW'(ROWS - 1);
    localparam logic [IW-1:0] ROWS_I  = IW'(ROWS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_BLANK,
        S_SHOW
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bri_q, bri_d;
    logic [LW-1:0]   layer_d;
    logic [RW-1:0]   row_d;
    logic [COLS-1:0] data_d;
    logic [COLS-1:0] fbuf [NR];
    logic [IW-1:0]   ridx;
    logic            load_fb;
    logic            last_row;
    logic            en_n_d;
    logic            load_d;
    logic            done_d;

    assign last_row = (Layer == L_LAST) && (Row == R_LAST);
    assign ridx     = IW'(Layer) * ROWS_I + IW'(Row);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bri_d   = bri_q;
        layer_d = Layer;
        row_d   = Row;
        data_d  = Data;
        load_fb = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (Run) state_d = S_LOAD;
            end
            S_LOAD: begin
                load_fb = 1'b1;
                layer_d = '0;
                row_d   = '0;
                cnt_d   = '0;
                state_d = S_BLANK;
            end
            S_BLANK: begin
                if (cnt_q == BL_LAST) begin
                    data_d  = fbuf[ridx];
                    bri_d   = Brightness;
                    cnt_d   = '0;
                    state_d = S_SHOW;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SHOW: begin
                if (cnt_q == DW_LAST) begin
                    cnt_d = '0;
                    if (last_row) begin
                        // Run is only honoured at frame end: no partial frames
                        state_d = Run ? S_LOAD : S_IDLE;
                        if (!Run) begin
                            layer_d = '0;
                            row_d   = '0;
                        end
                    end else begin
                        state_d = S_BLANK;
                        if (Row == R_LAST) begin
                            row_d   = '0;
                            layer_d = Layer + LW'(1);
                        end else begin
                            row_d = Row + RW'(1);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they align with state
    always_comb begin
        en_n_d = !((state_d == S_SHOW) && (int'(cnt_d) < int'(bri_d)));
        load_d = (state_d == S_LOAD);
        done_d = (state_d == S_SHOW) && (cnt_d == DW_LAST) &&
                 (layer_d == L_LAST) && (row_d == R_LAST);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bri_q      <= '0;
            Layer      <= '0;
            Row        <= '0;
            Data       <= '0;
            Enable_n   <= 1'b1;
            Frame_load <= 1'b0;
            Frame_done <= 1'b0;
            for (int i = 0; i < NR; i++) fbuf[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bri_q      <= bri_d;
            Layer      <= layer_d;
            Row        <= row_d;
            Data       <= data_d;
            Enable_n   <= en_n_d;
            Frame_load <= load_d;
            Frame_done <= done_d;
            if (load_fb) begin
                for (int i = 0; i < NR; i++) fbuf[i] <= Cells[i*COLS +: COLS];
            end
        end
    end

endmodule

// File: tb/tb_cube_scanner.sv
// Bench for cube_scanner: default and small configurations run side by side
// against a frame-timeline reference model.
module tb_cube_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         run;
    logic [511:0] cells;
    logic [4:0]   bri_b;
    logic [1:0]   bri_s;

    logic [2:0] lay_b;
    logic [2:0] row_b;
    logic [7:0] dat_b;
    logic       en_b, ld_b, dn_b;

    logic [2:0] lay_s;
    logic [1:0] row_s;
    logic [3:0] dat_s;
    logic       en_s, ld_s, dn_s;

    cube_scanner u_big (
        .Clk(clk), .Rst_n(rst_n), .Cells(cells), .Run(run),
        .Brightness(bri_b), .Layer(lay_b), .Row(row_b), .Data(dat_b),
        .Enable_n(en_b), .Frame_load(ld_b), .Frame_done(dn_b)
    );

    cube_scanner #(
        .COLS(4), .ROWS(3), .LAYERS(5), .DWELL(3), .BLANK(1)
    ) u_small (
        .Clk(clk), .Rst_n(rst_n), .Cells(cells[59:0]), .Run(run),
        .Brightness(bri_s), .Layer(lay_s), .Row(row_s), .Data(dat_s),
        .Enable_n(en_s), .Frame_load(ld_s), .Frame_done(dn_s)
    );

    int checks = 0;
    int fails  = 0;
    int cycn   = 0;
    bit rnd    = 0;
    int nload_b = 0;
    int ndone_b = 0;

    int P_C [2] = '{8, 4};
    int P_R [2] = '{8, 3};
    int P_N [2] = '{64, 15};
    int P_D [2] = '{16, 3};
    int P_B [2] = '{2, 1};

    // model: in-frame flag, clocks since LOAD, snapshot, row brightness, data
    bit           inf   [2];
    int           t     [2];
    logic [511:0] fb    [2];
    int           bri   [2];
    int           mdata [2];

    task automatic chk(input string tag, input int d,
                       input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s dut%0d cyc%0d obs=%0h exp=%0h", tag, d, cycn, o, e);
        end
    endtask

    task automatic mreset();
        for (int d = 0; d < 2; d++) begin
            inf[d] = 0; t[d] = 0; fb[d] = '0; bri[d] = 0; mdata[d] = 0;
        end
    endtask

    task automatic adv(input int d, input int b_in);
        int per, tot, k, p;
        logic [511:0] tmp;
        per = P_B[d] + P_D[d];
        tot = 1 + P_N[d] * per;
        if (!inf[d]) begin
            if (run) begin inf[d] = 1; t[d] = 0; end
        end else begin
            if (t[d] == 0) begin
                fb[d] = cells & ((512'd1 << (P_N[d] * P_C[d])) - 512'd1);
            end else begin
                k = (t[d] - 1) / per;
                p = (t[d] - 1) % per;
                if (p == P_B[d] - 1) begin
                    bri[d]   = b_in;
                    tmp      = fb[d] >> (k * P_C[d]);
                    mdata[d] = int'(tmp[7:0]) & ((1 << P_C[d]) - 1);
                end
            end
            if (t[d] == tot - 1) begin
                if (run) t[d] = 0;
                else inf[d] = 0;
            end else begin
                t[d]++;
            end
        end
    endtask

    task automatic mcheck(input int d);
        logic [31:0] lay, row, dat;
        logic en, ld, dn;
        int per, k, p, s;
        int e_lay, e_row;
        bit e_en, e_ld, e_dn, chk_lr;
        per = P_B[d] + P_D[d];
        if (d == 0) begin
            lay = 32'(lay_b); row = 32'(row_b); dat = 32'(dat_b);
            en = en_b; ld = ld_b; dn = dn_b;
        end else begin
            lay = 32'(lay_s); row = 32'(row_s); dat = 32'(dat_s);
            en = en_s; ld = ld_s; dn = dn_s;
        end
        e_en = 1; e_ld = 0; e_dn = 0; chk_lr = 1; e_lay = 0; e_row = 0;
        if (inf[d] && t[d] == 0) begin
            e_ld = 1; chk_lr = 0;
        end else if (inf[d]) begin
            k = (t[d] - 1) / per;
            p = (t[d] - 1) % per;
            e_lay = k / P_R[d];
            e_row = k % P_R[d];
            if (p >= P_B[d]) begin
                s    = p - P_B[d];
                e_en = !(s < bri[d]);
                e_dn = (k == P_N[d] - 1) && (s == P_D[d] - 1);
            end
        end
        chk("enable_n", d, 32'(en), 32'(e_en));
        chk("frame_load", d, 32'(ld), 32'(e_ld));
        chk("frame_done", d, 32'(dn), 32'(e_dn));
        chk("data", d, dat, mdata[d]);
        if (chk_lr) begin
            chk("layer", d, lay, e_lay);
            chk("row", d, row, e_row);
        end
    endtask

    task automatic cyc();
        if (rnd) begin
            bri_b = 5'($urandom_range(0, 31));
            bri_s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)
                for (int i = 0; i < 16; i++) cells[i*32 +: 32] = $urandom();
        end
        adv(0, int'(bri_b));
        adv(1, int'(bri_s));
        @(posedge clk);
        #1;
        cycn++;
        if (ld_b) nload_b++;
        if (dn_b) ndone_b++;
        mcheck(0);
        mcheck(1);
    endtask

    function automatic bit at_row10();
        return inf[0] && (t[0] == 1 + 10 * 18);
    endfunction

    function automatic bit in_show_lit();
        return inf[0] && (t[0] >= 1) && (((t[0] - 1) % 18) >= 2);
    endfunction

    initial begin
        int n0, d0;
        bit hit;
        rst_n = 1'b0; run = 1'b0; cells = '0; bri_b = '0; bri_s = '0;
        mreset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mcheck(0);
        mcheck(1);

        // idle with Run low
        repeat (100) cyc();
        chk("idle_no_load", 0, nload_b, 0);

        // byte k = k, full brightness
        for (int k = 0; k < 64; k++) cells[k*8 +: 8] = 8'(k);
        bri_b = 5'd16; bri_s = 2'd3; run = 1'b1;
        repeat (1153) cyc();

        // PWM 5 with mid-frame change to all ones (tearing)
        bri_b = 5'd5; bri_s = 2'd1;
        repeat (600) cyc();
        cells = '1;
        repeat (553 + 1153) cyc();

        bri_b = 5'd0; bri_s = 2'd0;
        repeat (1153) cyc();
        bri_b = 5'd20; bri_s = 2'd2;
        repeat (1153) cyc();

        // randomized brightness and cell data
        rnd = 1;
        repeat (1500) cyc();
        rnd = 0;

        // Run drop at row 10
        bri_b = 5'd9;
        hit = 0;
        for (int i = 0; i < 2000; i++) begin
            if (at_row10()) begin hit = 1; break; end
            cyc();
        end
        chk("reach_row10", 0, 32'(hit), 32'd1);
        run = 1'b0;
        n0 = nload_b; d0 = ndone_b;
        repeat (1200) cyc();
        chk("drop_no_reload", 0, nload_b - n0, 0);
        chk("drop_done_once", 0, ndone_b - d0, 1);

        // async reset in the middle of a lit row
        run = 1'b1; bri_b = 5'd16;
        hit = 0;
        for (int i = 0; i < 2000; i++) begin
            if (in_show_lit()) begin hit = 1; break; end
            cyc();
        end
        chk("reach_show", 0, 32'(hit), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_en_b", 0, 32'(en_b), 32'd1);
        chk("async_en_s", 1, 32'(en_s), 32'd1);
        chk("async_layer", 0, 32'(lay_b), 32'd0);
        chk("async_row", 0, 32'(row_b), 32'd0);
        chk("async_data", 0, 32'(dat_b), 32'd0);
        chk("async_load", 0, 32'(ld_b), 32'd0);
        mreset();
        run = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/cube_scanner.md
Name: cube_scanner

Overview:
- Parametrised LED-cube scan driver; next generation of the fixed 8x8x8 row scanner.
- Snapshots the cell array once per frame (double-buffered, no tearing).
- Scans layer/row with configurable dwell and blanking, and gives PWM brightness control via the active-low enable.
- Sits between the simulation core (cell array producer) and the cube pin drivers.

Parameters:
COLS, 8, data bits per row (LEDs driven simultaneously)
ROWS, 8, rows per layer
LAYERS, 8, layers in cube
DWELL, 16, clocks each row is displayed (>=1)
BLANK, 2, clocks of forced-off time before each row (>=1)
BW, $clog2(DWELL+1), width of Brightness

Ports:
Clk  in  1  system clock, all state on rising edge
Rst_n  in  1  asynchronous active-low reset
Cells  in  LAYERS*ROWS*COLS  cell array; cell (l,r,c) at bit l*ROWS*COLS + r*COLS + c
Run  in  1  level; high = scan continuously
Brightness  in  BW  on-clocks per dwell (0 = dark, >=DWELL = full)
Layer  out  $clog2(LAYERS)  current layer select
Row  out  $clog2(ROWS)  current row select
Data  out  COLS  current row data
Enable_n  out  1  LED enable, active-low
Frame_load  out  1  1-clock pulse: Cells captured into frame buffer
Frame_done  out  1  1-clock pulse: last row of frame finished

Behaviour:
- Reset (async, Rst_n low): state IDLE, Layer=0, Row=0, Data=0, Enable_n=1, Frame_load=0, Frame_done=0, counters 0, frame buffer cleared. Outputs go blank immediately, mid-row included.
- All outputs registered; Layer/Row/Data change only while Enable_n=1.
- States: IDLE, LOAD, BLANK, SHOW.
- IDLE: Enable_n=1. Run=1 -> LOAD next clock.
- LOAD (1 clock): fbuf <= Cells; Frame_load=1; Layer<=0, Row<=0; -> BLANK.
- BLANK (BLANK clocks): Enable_n=1.
  - Last BLANK clock: Data <= fbuf[(Layer*ROWS+Row)*COLS +: COLS]; latch Brightness into bri_q; dwell cnt<=0; -> SHOW.
- SHOW (DWELL clocks, cnt 0..DWELL-1): Enable_n = (cnt >= bri_q).
  - bri_q fixed for the row; Brightness changes take effect at the next row.
  - Last SHOW clock (cnt=DWELL-1), row not final: Row+1; at Row=ROWS-1, Row<=0 and Layer+1. Next state BLANK. Enable_n=1 on the next clock.
  - Last SHOW clock of Layer=LAYERS-1, Row=ROWS-1: Frame_done=1 (1 clock). Run=1 -> LOAD, otherwise -> IDLE with Layer/Row to 0.
- Run deasserted mid-frame: current frame completes; no partial frames.
- Cells changes outside LOAD have no visible effect until the next LOAD.
- Frame period with Run held high: 1 + LAYERS*ROWS*(BLANK+DWELL) clocks. Defaults give 1153.
- Row counter and layer counter wrap independently of power-of-two sizes (compare to ROWS-1 / LAYERS-1; no natural overflow).
- Enable_n may be low in SHOW state only.

Test Plan:
- Reset/idle: Rst_n=0 then 1, Run=0 for 100 clocks -> Enable_n=1, Layer=0, Row=0, Data=0, no pulses. Assert Rst_n=0 mid-SHOW -> Enable_n=1 same cycle (async).
- Scan order and data: defaults, Cells with byte k = k (k=0..63), Brightness=16, Run=1.
  - Frame_load at clock 1.
  - Row k shows Data=k with Layer=k/8, Row=k%8.
  - Enable_n low for 16 clocks, high for 2.
  - Frame_done after 1153 clocks, then LOAD again.
- PWM: Brightness=5 -> per row exactly 5 clocks Enable_n=0 at dwell start, then 11+2 high. Brightness=0 -> Enable_n never 0. Brightness=20 -> 16 low.
- Tearing: change Cells mid-frame to all 1s -> rows of the current frame still show old data. All-1s data (0xFF) first appears in the row after the next Frame_load.
- Run drop: deassert Run at row 10 -> frame finishes through row 63, Frame_done pulses, state IDLE, no further Frame_load.
- Non-default params: COLS=4, ROWS=3, LAYERS=5, DWELL=3, BLANK=1 -> Row wraps 2->0, Layer 4->0, period 1+15*4=61 clocks, Data slices correct.
